// File: rtl/multi_digit_counter.sv
// Cascaded modulo counter: DIGITS stages of 0..MAX_VAL, up/down, load/clear, carry and sticky wrap.
// Define MDC_SATURATE_EN to hold at the terminal state instead of wrapping.
module multi_digit_counter #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MAX_VAL = 10,
    parameter int unsigned DIGITS  = 2
) (
    input  logic                        clk,
    input  logic                        a_reset,
    input  logic                        enable,
    input  logic                        up_dn,
    input  logic                        sclr,
    input  logic                        load,
    input  logic [DIGITS*DIGIT_W-1:0]   load_val,
    output logic [DIGITS*DIGIT_W-1:0]   count,
    output logic                        carry_out,
    output logic                        wrapped
);

    localparam int unsigned CNT_W = DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_VAL);

    logic [CNT_W-1:0]   count_q, count_d;
    logic               wrapped_q, wrapped_d;
    logic [CNT_W-1:0]   stepped;
    logic [CNT_W-1:0]   clamped;
    logic [DIGIT_W-1:0] dig;
    logic [DIGIT_W-1:0] lv;
    logic               ripple;
    logic               terminal;

    // Per-digit step: a digit moves only when every lower digit sits at its terminal value.
    always_comb begin
        stepped = count_q;
        clamped = '0;
        dig     = '0;
        lv      = '0;
        ripple  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = count_q[i*DIGIT_W +: DIGIT_W];
            if (ripple) begin
                if (up_dn) begin
                    stepped[i*DIGIT_W +: DIGIT_W] = (dig == MAX_D) ? '0 : dig + DIGIT_W'(1);
                end else begin
                    stepped[i*DIGIT_W +: DIGIT_W] = (dig == '0) ? MAX_D : dig - DIGIT_W'(1);
                end
            end
            ripple = ripple & (up_dn ? (dig == MAX_D) : (dig == '0));
            lv = load_val[i*DIGIT_W +: DIGIT_W];
            clamped[i*DIGIT_W +: DIGIT_W] = (lv > MAX_D) ? MAX_D : lv;
        end
        terminal = ripple;
    end

    assign carry_out = enable & ~sclr & ~load & terminal;

    // Priority: sclr > load > enable > hold.
    always_comb begin
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (sclr) begin
            count_d   = '0;
            wrapped_d = 1'b0;
        end else if (load) begin
            count_d   = clamped;
            wrapped_d = 1'b0;
        end else if (enable) begin
            if (terminal) begin
                wrapped_d = 1'b1;
`ifdef MDC_SATURATE_EN
                count_d   = count_q;
`else
                count_d   = stepped;
`endif
            end else begin
                count_d = stepped;
            end
        end
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;

endmodule
